mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-clock arbiter and sequencer for the unified 32-bit instruction/data memory of the MIPS core. It shares one synchronous single-port memory between three requesters:

- the boot loader port, which fills the program image;
- the instruction-fetch stage;
- the data-memory stage.

It also sequences the core through LOAD, RUN and HALT phases. It sits between the pipeline stages and the memory array, and replaces direct hierarchical writes into the memory.

## Interface
Parameters:
- AW, 10, word address width (1024-word memory)
- DW, 32, data width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win

Ports:
- clk1  in  1  sole clock, rising edge; reset is synchronous and active-low
- rst_n  in  1  synchronous active-low reset
- load_mode  in  1  level; 1 requests the loader phase
- halt_i  in  1  one-cycle pulse from the pipeline when HLT retires
- ld_req / ld_addr / ld_wdata  in  1/AW/DW  loader write request (write-only)
- ld_gnt  out  1  loader write accepted this cycle
- if_req / if_addr  in  1/AW  fetch read request
- if_gnt / if_rvalid  out  1/1  fetch accepted; fetch read data valid
- if_rdata  out  DW  fetch read data
- dm_req / dm_we / dm_addr / dm_wdata  in  1/1/AW/DW  data request; dm_we=1 is a write
- dm_gnt / dm_rvalid  out  1/1  data accepted; data read data valid
- dm_rdata  out  DW  data read data
- mem_en / mem_we / mem_addr / mem_wdata  out  1/1/AW/DW  memory port
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0
- halted  out  1  high in HALT
- arb_state  out  2  current phase encoding

## Operation
States and transitions:
- States: LOAD=2'b00, RUN=2'b01, HALT=2'b10. Reset enters LOAD.
- LOAD→RUN when load_mode=0. RUN→HALT on halt_i=1. RUN→LOAD or HALT→LOAD when load_mode=1.
- load_mode=1 and halt_i=1 in the same cycle → LOAD (load_mode wins).

Service per state:
- LOAD: only the loader is served. if_gnt=0 and dm_gnt=0.
- RUN: priority is data > fetch, except that when starve_cnt==STARVE_MAX a pending fetch beats data for that one cycle. The loader is ignored.
- HALT: data is still served so in-flight stores drain. Fetch is never granted.

Grant rules:
- Exactly one grant at most per cycle.
- A grant is issued only when the corresponding req=1 in an eligible state.
- mem_en = OR of all grants.

Starvation counter:
- Increments each RUN cycle with if_req=1 and if_gnt=0, and saturates at STARVE_MAX.
- Clears on if_gnt, on if_req=0, or on any cycle not in RUN.

Read return:
- A registered owner tag records which requester issued a read (if, dm, or none).
- if_rvalid or dm_rvalid is asserted the cycle after the grant. The matching rdata equals mem_rdata. The non-owner rdata output holds its last value.
- Writes never raise rvalid.

Reset values: arb_state=LOAD, halted=0, all rvalid=0, owner tag=none, starve_cnt=0, if_rdata=0, dm_rdata=0. Grants are 0 because they are gated by state and reset.

## Timing
- Grants and mem_en/we/addr/wdata are combinational from req and registered state, with 0-cycle latency. Requesters must hold req/addr/wdata stable until their gnt is seen.
- Read latency: rvalid arrives exactly 1 cycle after gnt. Back-to-back reads give rvalid every cycle.
- A state transition takes effect the cycle after the triggering input. Grants in the triggering cycle follow the old state.
- A read granted in the last RUN cycle still returns rvalid in the following LOAD/HALT cycle.
- rst_n=0 with a read outstanding: rvalid stays 0 and the read is dropped.
- Address wrap is the caller's responsibility. The arbiter passes addresses unmodified, so the full AW range is legal.

## Structure
- Package mem_arb_pkg:
  - phase encodings LOAD/RUN/HALT;
  - owner-tag encodings OWN_NONE/OWN_IF/OWN_DM;
  - the starve counter width function clog2(STARVE_MAX+1).
- Sub-module mem_arb_starve_ctr: the saturating starvation counter, with inputs inc/clr and output at_max.
- The top level holds the FSM, the grant logic, the owner tag and the rdata registers.

## Test plan
- Reset then load: with load_mode=1, three loader writes to addr 0,1,2 (0x2001000A, 0x20020014, 0xFC000000). Required: ld_gnt=1 each cycle, mem_we=1, and if_gnt=0 throughout.
- Fetch in RUN: load_mode→0, then if_req to addr 1. Required: if_gnt same cycle and if_rvalid next cycle with if_rdata=0x20020014.
- Contention: if_req and dm_req (read, addr 0) held together. Required: dm_gnt for 4 cycles, then if_gnt on cycle 5, then dm_gnt resumes; starve_cnt returns to 0.
- Halt drain: halt_i pulse, then if_req and dm store (addr 5, 0x0000001E). Required: halted=1 next cycle, if_gnt=0, dm_gnt=1, and a later read of addr 5 returns 0x1E.
- Simultaneous halt_i=1 and load_mode=1 in RUN. Required: arb_state=LOAD next cycle and halted=0.
- rst_n=0 the cycle after an if read grant. Required: if_rvalid=0, arb_state=LOAD, and all grants 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared encodings for the unified memory arbiter:
//   phase_e  - sequencer phase (LOAD / RUN / HALT), also driven on arb_state
//   owner_e  - which requester issued the read now in flight in the memory
//   clog2    - width helper, used to size the starvation counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } phase_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_DM   = 2'b10
    } owner_e;

    // Bits needed to hold the values 0 .. value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                width = i + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the requester handshakes and the memory port of the arbiter.
//   ld_*   : boot loader write request / grant
//   if_*   : instruction fetch read request / grant / read return
//   dm_*   : data stage read-or-write request / grant / read return
//   mem_*  : single synchronous memory port (rdata valid one cycle after a read)
// Modports:
//   slave  - the arbiter (takes requests, drives grants and the memory port)
//   master - the environment (requesters plus the memory array)
interface mem_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  ld_req, ld_addr, ld_wdata,
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output ld_gnt,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ld_req, ld_addr, ld_wdata,
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  ld_gnt,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr
// Saturating count of consecutive cycles in which a pending fetch was denied.
//   clk1   in  clock
//   rst_n  in  synchronous active-low reset
//   inc    in  fetch denied this cycle
//   clr    in  clear (fetch granted, fetch idle, or not in RUN); wins over inc
//   at_max out count has reached STARVE_MAX, fetch must win next
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAX_V = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_r;

    // Count denied fetch cycles, holding at MAX_V until cleared.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc && (cnt_r != MAX_V)) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_max = (cnt_r == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous single-port memory between the boot loader, the
// instruction fetch stage and the data stage, and sequences the core through
// LOAD -> RUN -> HALT.
//   clk1       in  clock (rising edge)
//   rst_n      in  synchronous active-low reset
//   load_mode  in  level, 1 = loader phase requested (dominates halt_i)
//   halt_i     in  pulse when HLT retires
//   bus        slave side of mem_port_arbiter_if (requests, grants, memory port)
//   halted     out high while in HALT
//   arb_state  out current phase encoding
// Grants and the memory port are combinational from requests and registered
// phase. Read data returns one cycle after the grant, steered by an owner tag.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic                     load_mode,
    input  logic                     halt_i,
    mem_port_arbiter_if.slave        bus,
    output logic                     halted,
    output logic [1:0]               arb_state
);

    phase_e        state_r;
    phase_e        state_nxt_s;
    owner_e        owner_r;
    owner_e        owner_nxt_s;
    logic [DW-1:0] if_hold_r;
    logic [DW-1:0] dm_hold_r;

    logic          ld_gnt_s;
    logic          if_gnt_s;
    logic          dm_gnt_s;
    logic          at_max_s;
    logic          starve_inc_s;
    logic          starve_clr_s;
    logic          if_ret_s;
    logic          dm_ret_s;
    logic [DW-1:0] if_rdata_s;
    logic [DW-1:0] dm_rdata_s;

    logic          mem_en_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;

    // Phase register.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next phase; load_mode beats a simultaneous halt.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (load_mode) state_nxt_s = LOAD;
                else           state_nxt_s = RUN;
            end
            RUN: begin
                if (load_mode)   state_nxt_s = LOAD;
                else if (halt_i) state_nxt_s = HALT;
                else             state_nxt_s = RUN;
            end
            HALT: begin
                if (load_mode) state_nxt_s = LOAD;
                else           state_nxt_s = HALT;
            end
            default: state_nxt_s = LOAD;
        endcase
    end

    // Grant selection; gated by rst_n so nothing reaches memory while the
    // phase register is still being reset.
    always_comb begin
        ld_gnt_s = 1'b0;
        if_gnt_s = 1'b0;
        dm_gnt_s = 1'b0;
        if (rst_n) begin
            case (state_r)
                LOAD: ld_gnt_s = bus.ld_req;
                RUN: begin
                    // Data normally wins; a starved fetch takes one cycle.
                    if (bus.if_req && (at_max_s || !bus.dm_req)) begin
                        if_gnt_s = 1'b1;
                    end else begin
                        dm_gnt_s = bus.dm_req;
                    end
                end
                HALT:    dm_gnt_s = bus.dm_req;
                default: ld_gnt_s = 1'b0;
            endcase
        end else begin
            ld_gnt_s = 1'b0;
        end
    end

    assign starve_inc_s = (state_r == RUN) && bus.if_req && !if_gnt_s;
    assign starve_clr_s = !starve_inc_s;

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .inc    (starve_inc_s),
        .clr    (starve_clr_s),
        .at_max (at_max_s)
    );

    // Memory port steering from the single active grant.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {DW{1'b0}};
        if (ld_gnt_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = 1'b1;
            mem_addr_s  = bus.ld_addr;
            mem_wdata_s = bus.ld_wdata;
        end else if (if_gnt_s) begin
            mem_en_s    = 1'b1;
            mem_addr_s  = bus.if_addr;
        end else if (dm_gnt_s) begin
            mem_en_s    = 1'b1;
            mem_we_s    = bus.dm_we;
            mem_addr_s  = bus.dm_addr;
            mem_wdata_s = bus.dm_wdata;
        end else begin
            mem_en_s    = 1'b0;
        end
    end

    // Owner of the read now in flight; writes leave no owner.
    always_comb begin
        owner_nxt_s = OWN_NONE;
        if (if_gnt_s) begin
            owner_nxt_s = OWN_IF;
        end else if (dm_gnt_s && !bus.dm_we) begin
            owner_nxt_s = OWN_DM;
        end else begin
            owner_nxt_s = OWN_NONE;
        end
    end

    // A reset cycle suppresses the return of a read that was in flight.
    assign if_ret_s   = rst_n && (owner_r == OWN_IF);
    assign dm_ret_s   = rst_n && (owner_r == OWN_DM);
    assign if_rdata_s = if_ret_s ? bus.mem_rdata : if_hold_r;
    assign dm_rdata_s = dm_ret_s ? bus.mem_rdata : dm_hold_r;

    // Owner tag and held read data (non-owner rdata keeps its last value).
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            owner_r   <= OWN_NONE;
            if_hold_r <= {DW{1'b0}};
            dm_hold_r <= {DW{1'b0}};
        end else begin
            owner_r   <= owner_nxt_s;
            if_hold_r <= if_rdata_s;
            dm_hold_r <= dm_rdata_s;
        end
    end

    assign bus.ld_gnt    = ld_gnt_s;
    assign bus.if_gnt    = if_gnt_s;
    assign bus.dm_gnt    = dm_gnt_s;
    assign bus.if_rvalid = if_ret_s;
    assign bus.dm_rvalid = dm_ret_s;
    assign bus.if_rdata  = if_rdata_s;
    assign bus.dm_rdata  = dm_rdata_s;
    assign bus.mem_en    = mem_en_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;

    assign halted    = (state_r == HALT);
    assign arb_state = state_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed table of cycles for the main scenarios, then randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic       clk1 = 1'b0;
    logic       rst_n;
    logic       load_mode;
    logic       halt_i;
    logic       halted;
    logic [1:0] arb_state;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .load_mode (load_mode),
        .halt_i    (halt_i),
        .bus       (bus),
        .halted    (halted),
        .arb_state (arb_state)
    );

    always #5 clk1 = ~clk1;

    // Memory array behind the port: synchronous, one-cycle read latency.
    logic [DW-1:0] mem_arr [0:(1<<AW)-1] = '{default: 32'h0};
    always @(posedge clk1) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem_arr[bus.mem_addr];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          rst, lm, hlt, lr;
        logic [AW-1:0] la;
        logic [31:0]   lw;
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr, dw;
        logic [AW-1:0] da;
        logic [31:0]   dd;
        logic          elg, eig, edg, ewe, eiv, edv;
        logic [1:0]    est;
        logic          ehl;
        logic [31:0]   eird, edrd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input int rst, lm, hlt, lr, la, input logic [31:0] lw,
                                 input int ir, ia, dr, dw, da, input logic [31:0] dd,
                                 input int lg, ig, dg, we, iv, dv, st, hl,
                                 input logic [31:0] ird, drd);
        vec_t r;
        r.rst = (rst != 0); r.lm = (lm != 0); r.hlt = (hlt != 0); r.lr = (lr != 0);
        r.la = AW'(la); r.lw = lw; r.ir = (ir != 0); r.ia = AW'(ia);
        r.dr = (dr != 0); r.dw = (dw != 0); r.da = AW'(da); r.dd = dd;
        r.elg = (lg != 0); r.eig = (ig != 0); r.edg = (dg != 0); r.ewe = (we != 0);
        r.eiv = (iv != 0); r.edv = (dv != 0); r.est = 2'(st); r.ehl = (hl != 0);
        r.eird = ird; r.edrd = drd;
        return r;
    endfunction

    task automatic apply(input vec_t v);
        rst_n = v.rst; load_mode = v.lm; halt_i = v.hlt;
        bus.ld_req = v.lr; bus.ld_addr = v.la; bus.ld_wdata = v.lw;
        bus.if_req = v.ir; bus.if_addr = v.ia;
        bus.dm_req = v.dr; bus.dm_we = v.dw; bus.dm_addr = v.da; bus.dm_wdata = v.dd;
    endtask

    // ---------------- behavioural reference model ----------------
    int            m_phase  = 0;   // 0 LOAD, 1 RUN, 2 HALT
    int            m_starve = 0;   // consecutive denied fetch cycles
    int            m_pend   = 0;   // 0 none, 1 fetch, 2 data read in flight
    logic [31:0]   m_pdata  = 32'h0;
    logic [31:0]   m_last_if = 32'h0;
    logic [31:0]   m_last_dm = 32'h0;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: 32'h0};

    // Predict this cycle's outputs, optionally compare, then advance one clock.
    task automatic model_cycle(input bit do_check);
        int          win;   // 0 none, 1 loader, 2 fetch, 3 data
        logic        e_we;
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
        logic        e_iv, e_dv;
        win = 0;
        if (rst_n) begin
            if (m_phase == 0 && bus.ld_req) win = 1;
            else if (m_phase == 1) begin
                if (bus.if_req && (m_starve >= SMAX || !bus.dm_req)) win = 2;
                else if (bus.dm_req) win = 3;
            end else if (m_phase == 2 && bus.dm_req) win = 3;
        end
        e_we   = (win == 1) || (win == 3 && bus.dm_we);
        e_addr = (win == 1) ? 32'(bus.ld_addr) : (win == 2) ? 32'(bus.if_addr) : 32'(bus.dm_addr);
        e_wd   = (win == 1) ? bus.ld_wdata : bus.dm_wdata;
        e_iv   = rst_n && (m_pend == 1);
        e_dv   = rst_n && (m_pend == 2);
        e_ird  = e_iv ? m_pdata : m_last_if;
        e_drd  = e_dv ? m_pdata : m_last_dm;
        if (do_check) begin
            chk("rnd ld_gnt", 32'(bus.ld_gnt), 32'(win == 1));
            chk("rnd if_gnt", 32'(bus.if_gnt), 32'(win == 2));
            chk("rnd dm_gnt", 32'(bus.dm_gnt), 32'(win == 3));
            chk("rnd mem_en", 32'(bus.mem_en), 32'(win != 0));
            if (win != 0) begin
                chk("rnd mem_we", 32'(bus.mem_we), 32'(e_we));
                chk("rnd mem_addr", 32'(bus.mem_addr), e_addr);
                if (e_we) chk("rnd mem_wdata", bus.mem_wdata, e_wd);
            end
            chk("rnd if_rvalid", 32'(bus.if_rvalid), 32'(e_iv));
            chk("rnd dm_rvalid", 32'(bus.dm_rvalid), 32'(e_dv));
            chk("rnd if_rdata", bus.if_rdata, e_ird);
            chk("rnd dm_rdata", bus.dm_rdata, e_drd);
            chk("rnd arb_state", 32'(arb_state), 32'(m_phase));
            chk("rnd halted", 32'(halted), 32'(m_phase == 2));
        end
        m_last_if = e_ird;
        m_last_dm = e_drd;
        if (!rst_n) begin
            m_phase = 0; m_starve = 0; m_pend = 0; m_last_if = 32'h0; m_last_dm = 32'h0;
        end else begin
            m_pend = 0;
            if (win == 2) begin m_pend = 1; m_pdata = ref_mem[bus.if_addr]; end
            if (win == 3 && !bus.dm_we) begin m_pend = 2; m_pdata = ref_mem[bus.dm_addr]; end
            if (win == 1) ref_mem[bus.ld_addr] = bus.ld_wdata;
            if (win == 3 && bus.dm_we) ref_mem[bus.dm_addr] = bus.dm_wdata;
            if (m_phase == 1 && bus.if_req && win != 2) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            else m_starve = 0;
            if (load_mode) m_phase = 0;
            else if (m_phase == 0) m_phase = 1;
            else if (m_phase == 1 && halt_i) m_phase = 2;
        end
    endtask

    initial begin
        logic lm_lvl;
        // rst lm hlt | lr la lw | ir ia | dr dw da dd | lg ig dg we | iv dv | st hl | ird drd
        tbl.push_back(row(0,1,0, 1,0,32'h2001000A, 0,0, 0,0,0,32'h0, 0,0,0,0, 0,0, 0,0, 32'h0,32'h0));
        tbl.push_back(row(1,1,0, 1,0,32'h2001000A, 0,0, 0,0,0,32'h0, 1,0,0,1, 0,0, 0,0, 32'h0,32'h0));
        tbl.push_back(row(1,1,0, 1,1,32'h20020014, 1,1, 0,0,0,32'h0, 1,0,0,1, 0,0, 0,0, 32'h0,32'h0));
        tbl.push_back(row(1,1,0, 1,2,32'hFC000000, 1,1, 1,0,0,32'h0, 1,0,0,1, 0,0, 0,0, 32'h0,32'h0));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 0,0, 0,0,0,32'h0, 0,0,0,0, 0,0, 0,0, 32'h0,32'h0));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 1,1, 0,0,0,32'h0, 0,1,0,0, 0,0, 1,0, 32'h0,32'h0));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 0,0, 0,0,0,32'h0, 0,0,0,0, 1,0, 1,0, 32'h20020014,32'h0));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 1,2, 1,0,0,32'h0, 0,0,1,0, 0,0, 1,0, 32'h0,32'h0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(row(1,0,0, 0,0,32'h0, 1,2, 1,0,0,32'h0, 0,0,1,0, 0,1, 1,0, 32'h0,32'h2001000A));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 1,2, 1,0,0,32'h0, 0,1,0,0, 0,1, 1,0, 32'h0,32'h2001000A));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 1,2, 1,0,0,32'h0, 0,0,1,0, 1,0, 1,0, 32'hFC000000,32'h0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(row(1,0,0, 0,0,32'h0, 1,2, 1,0,0,32'h0, 0,0,1,0, 0,1, 1,0, 32'h0,32'h2001000A));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 1,2, 1,0,0,32'h0, 0,1,0,0, 0,1, 1,0, 32'h0,32'h2001000A));
        tbl.push_back(row(1,0,1, 0,0,32'h0, 0,0, 0,0,0,32'h0, 0,0,0,0, 1,0, 1,0, 32'hFC000000,32'h0));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 1,3, 1,1,5,32'h0000001E, 0,0,1,1, 0,0, 2,1, 32'h0,32'h0));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 0,0, 1,0,5,32'h0, 0,0,1,0, 0,0, 2,1, 32'h0,32'h0));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 0,0, 0,0,0,32'h0, 0,0,0,0, 0,1, 2,1, 32'h0,32'h0000001E));
        tbl.push_back(row(1,1,0, 0,0,32'h0, 0,0, 0,0,0,32'h0, 0,0,0,0, 0,0, 2,1, 32'h0,32'h0));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 0,0, 0,0,0,32'h0, 0,0,0,0, 0,0, 0,0, 32'h0,32'h0));
        tbl.push_back(row(1,1,1, 0,0,32'h0, 0,0, 0,0,0,32'h0, 0,0,0,0, 0,0, 1,0, 32'h0,32'h0));
        tbl.push_back(row(1,1,1, 0,0,32'h0, 0,0, 0,0,0,32'h0, 0,0,0,0, 0,0, 0,0, 32'h0,32'h0));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 0,0, 0,0,0,32'h0, 0,0,0,0, 0,0, 0,0, 32'h0,32'h0));
        tbl.push_back(row(1,0,0, 0,0,32'h0, 1,1, 0,0,0,32'h0, 0,1,0,0, 0,0, 1,0, 32'h0,32'h0));
        tbl.push_back(row(0,0,0, 0,0,32'h0, 1,1, 0,0,0,32'h0, 0,0,0,0, 0,0, 1,0, 32'h0,32'h0));
        tbl.push_back(row(1,1,0, 0,0,32'h0, 1,1, 0,0,0,32'h0, 0,0,0,0, 0,0, 0,0, 32'h0,32'h0));

        // Reset preamble.
        apply(row(0,1,0, 0,0,32'h0, 0,0, 0,0,0,32'h0, 0,0,0,0, 0,0, 0,0, 32'h0,32'h0));
        repeat (2) begin
            @(negedge clk1);
            #1;
            model_cycle(1'b0);
        end

        // Directed scenarios, one table row per clock.
        foreach (tbl[k]) begin
            @(negedge clk1);
            apply(tbl[k]);
            #1;
            chk($sformatf("row%0d ld_gnt", k), 32'(bus.ld_gnt), 32'(tbl[k].elg));
            chk($sformatf("row%0d if_gnt", k), 32'(bus.if_gnt), 32'(tbl[k].eig));
            chk($sformatf("row%0d dm_gnt", k), 32'(bus.dm_gnt), 32'(tbl[k].edg));
            chk($sformatf("row%0d mem_en", k), 32'(bus.mem_en), 32'(tbl[k].elg | tbl[k].eig | tbl[k].edg));
            if (tbl[k].elg | tbl[k].eig | tbl[k].edg)
                chk($sformatf("row%0d mem_we", k), 32'(bus.mem_we), 32'(tbl[k].ewe));
            chk($sformatf("row%0d if_rvalid", k), 32'(bus.if_rvalid), 32'(tbl[k].eiv));
            chk($sformatf("row%0d dm_rvalid", k), 32'(bus.dm_rvalid), 32'(tbl[k].edv));
            chk($sformatf("row%0d arb_state", k), 32'(arb_state), 32'(tbl[k].est));
            chk($sformatf("row%0d halted", k), 32'(halted), 32'(tbl[k].ehl));
            if (tbl[k].eiv) chk($sformatf("row%0d if_rdata", k), bus.if_rdata, tbl[k].eird);
            if (tbl[k].edv) chk($sformatf("row%0d dm_rdata", k), bus.dm_rdata, tbl[k].edrd);
            model_cycle(1'b0);
        end

        // Randomized traffic against the model.
        lm_lvl = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk1);
            if ($urandom_range(0, 29) == 0) lm_lvl = !lm_lvl;
            rst_n        = ($urandom_range(0, 99) != 0);
            load_mode    = lm_lvl;
            halt_i       = ($urandom_range(0, 19) == 0);
            bus.ld_req   = ($urandom_range(0, 1) == 1);
            bus.ld_addr  = AW'($urandom_range(0, 15));
            bus.ld_wdata = $urandom;
            bus.if_req   = ($urandom_range(0, 3) != 0);
            bus.if_addr  = AW'($urandom_range(0, 15));
            bus.dm_req   = ($urandom_range(0, 3) != 0);
            bus.dm_we    = ($urandom_range(0, 2) == 0);
            bus.dm_addr  = AW'($urandom_range(0, 15));
            bus.dm_wdata = $urandom;
            #1;
            model_cycle(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
